// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 Hz timing constants.
// Imported by the sync generator and by downstream colour/font blocks, so
// every block agrees on the visible-area limits and the sync pulse windows.
// Contents: H_*/V_* porch and pulse defaults, derived totals, sync windows,
// coordinate width, default clock divider and a small range helper.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_RETRACE = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_RETRACE = 2;
    localparam int V_BACK    = 33;
    localparam int CLK_DIV   = 4;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    // Inclusive sync windows (656..751 and 490..491 with the defaults).
    localparam int HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int HSYNC_END   = HSYNC_START + H_RETRACE - 1;
    localparam int VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int VSYNC_END   = VSYNC_START + V_RETRACE - 1;

    // True when lo <= v <= hi.
    function automatic logic in_range(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable generator.
// Counts system clocks modulo CLK_DIV and emits a registered one-clock pulse
// in the cycle after the counter reaches CLK_DIV-1. With CLK_DIV = 1 the
// pulse is held high on every clock after the first post-reset edge.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   p_tick out one-clock pulse every CLK_DIV clocks
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_count <= '0;
            p_tick    <= 1'b0;
        end else begin
            p_tick    <= (div_count == DIV_LAST);
            div_count <= (div_count == DIV_LAST) ? '0 : div_count + DIV_ONE;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator (640x480@60 Hz by default, from a 100 MHz clock).
// Produces pixel-rate enable, registered active-low hsync/vsync, video_on,
// pixel coordinates and a frame-start pulse. Downstream logic is qualified
// by p_tick.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   hsync      out horizontal sync, active low, registered
//   vsync      out vertical sync, active low, registered
//   video_on   out high while (pixel_x, pixel_y) is in the visible area
//   p_tick     out one-clock pulse per pixel period
//   pixel_x    out current column, 0..H_TOTAL-1
//   pixel_y    out current line, 0..V_TOTAL-1
//   frame_tick out one-clock pulse on the p_tick of pixel (0,0)
module vga_sync_gen #(
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_RETRACE = vga_timing_pkg::H_RETRACE,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_RETRACE = vga_timing_pkg::V_RETRACE,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               video_on,
    output logic                               p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_x,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_y,
    output logic                               frame_tick
);

    import vga_timing_pkg::*;

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    // Counters are fixed at COORD_W bits; reject geometries that cannot fit.
    if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_RETRACE - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    logic [COORD_W-1:0] h_count, v_count;
    logic [COORD_W-1:0] h_next, v_next;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    // Next-state counters; the line wrap and frame wrap share one edge.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (p_tick) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + ONE;
            end else begin
                h_next = h_count + ONE;
            end
        end
    end

    // Syncs are decoded from the next-state counters so that the registered
    // sync changes on the same edge as the coordinate it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
            hsync   <= !in_range(h_next, HS_START, HS_END);
            vsync   <= !in_range(v_next, VS_START, VS_END);
        end
    end

    assign pixel_x    = h_count;
    assign pixel_y    = v_count;
    assign video_on   = (h_count < H_VIS) && (v_count < V_VIS);
    assign frame_tick = p_tick && (h_count == '0) && (v_count == '0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. Three instances share one clock:
//   u_std   default geometry, CLK_DIV = 4 (reset, tick spacing, one line)
//   u_fast  default geometry, CLK_DIV = 1 (continuous tick, line length)
//   u_small 16/2/3/2 x 8/2/2/3 geometry, CLK_DIV = 2 (whole frame, video_on
//           boundaries, vsync window, frame_tick, mid-frame reset)
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_std, rst_fast, rst_small;

    logic       hs_s, vs_s, vo_s, pt_s, ft_s;
    logic [9:0] px_s, py_s;
    logic       hs_f, vs_f, vo_f, pt_f, ft_f;
    logic [9:0] px_f, py_f;
    logic       hs_m, vs_m, vo_m, pt_m, ft_m;
    logic [9:0] px_m, py_m;

    vga_sync_gen u_std (
        .clk(clk), .reset(rst_std), .hsync(hs_s), .vsync(vs_s), .video_on(vo_s),
        .p_tick(pt_s), .pixel_x(px_s), .pixel_y(py_s), .frame_tick(ft_s)
    );

    vga_sync_gen #(.CLK_DIV(1)) u_fast (
        .clk(clk), .reset(rst_fast), .hsync(hs_f), .vsync(vs_f), .video_on(vo_f),
        .p_tick(pt_f), .pixel_x(px_f), .pixel_y(py_f), .frame_tick(ft_f)
    );

    vga_sync_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_RETRACE(3), .H_BACK(2),
        .V_DISPLAY(8), .V_FRONT(2), .V_RETRACE(2), .V_BACK(3),
        .CLK_DIV(2)
    ) u_small (
        .clk(clk), .reset(rst_small), .hsync(hs_m), .vsync(vs_m), .video_on(vo_m),
        .p_tick(pt_m), .pixel_x(px_m), .pixel_y(py_m), .frame_tick(ft_m)
    );

    // Observed-signal mux so the helper tasks work on whichever DUT is selected.
    int         sel;
    logic       o_hs, o_vs, o_vo, o_pt, o_ft;
    logic [9:0] o_px, o_py;

    always_comb begin
        o_hs = hs_s; o_vs = vs_s; o_vo = vo_s; o_pt = pt_s; o_ft = ft_s;
        o_px = px_s; o_py = py_s;
        case (sel)
            1: begin
                o_hs = hs_f; o_vs = vs_f; o_vo = vo_f; o_pt = pt_f; o_ft = ft_f;
                o_px = px_f; o_py = py_f;
            end
            2: begin
                o_hs = hs_m; o_vs = vs_m; o_vo = vo_m; o_pt = pt_m; o_ft = ft_m;
                o_px = px_m; o_py = py_m;
            end
            default: ;
        endcase
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance n clocks and sample 1 ns after the last rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to the next sample where p_tick is high; report clocks taken.
    task automatic next_pix(input int budget, output int clks);
        clks = 0;
        do begin
            tick(1);
            clks++;
        end while (o_pt !== 1'b1 && clks < budget);
        if (o_pt !== 1'b1) check("ptick_timeout", o_pt, 1);
    endtask

    task automatic goto_pix(input int x, input int y, input int max_steps);
        int c;
        int steps;
        steps = 0;
        while (!(o_pt === 1'b1 && o_px == x && o_py == y) && steps < max_steps) begin
            next_pix(8, c);
            steps++;
        end
        check("goto_x", o_px, x);
        check("goto_y", o_py, y);
    endtask

    int   c, n, steps, bad;
    int   hs_low, hs_min, hs_max, vs_low, vs_min, vs_max, ft_cnt, vo_cnt, pt_low;
    logic vo_a, vo_b, vo_c, vo_d;

    initial begin
        rst_std = 1'b1; rst_fast = 1'b1; rst_small = 1'b1; sel = 0;
        vo_a = 1'bx; vo_b = 1'bx; vo_c = 1'bx; vo_d = 1'bx;

        // ---------------- CLK_DIV = 4, default geometry ----------------
        tick(3);
        check("rst_px", o_px, 0);
        check("rst_py", o_py, 0);
        check("rst_hsync", o_hs, 1);
        check("rst_vsync", o_vs, 1);
        check("rst_ptick", o_pt, 0);
        check("rst_frame_tick", o_ft, 0);
        check("rst_video_on", o_vo, 1);

        rst_std = 1'b0;
        tick(3);
        check("tick_not_before_clk4", o_pt, 0);
        tick(1);
        check("tick_at_clk4", o_pt, 1);
        check("first_frame_tick", o_ft, 1);
        check("first_px", o_px, 0);

        next_pix(8, c);
        check("tick_period", c, 4);
        check("px_step_1", o_px, 1);
        tick(1);
        check("tick_one_clk_wide", o_pt, 0);
        check("px_step_2", o_px, 2);
        next_pix(8, c);
        check("tick_rest_of_period", c, 3);

        // Scan the rest of line 0.
        steps = 0; bad = 0; hs_low = 0; hs_min = 1023; hs_max = 0; vs_low = 0; ft_cnt = 0;
        while (o_px != 799 && steps < 900) begin
            next_pix(8, c);
            steps++;
            if (c != 4) bad++;
            if (o_hs === 1'b0) begin
                hs_low++;
                if (o_px < hs_min) hs_min = o_px;
                if (o_px > hs_max) hs_max = o_px;
            end
            if (o_vs === 1'b0) vs_low++;
            if (o_ft === 1'b1) ft_cnt++;
            if (o_px == 639) vo_a = o_vo;
            if (o_px == 640) vo_b = o_vo;
        end
        check("line_period_errors", bad, 0);
        check("hsync_low_ticks", hs_low, 96);
        check("hsync_first_low_px", hs_min, 656);
        check("hsync_last_low_px", hs_max, 751);
        check("vsync_low_line0", vs_low, 0);
        check("frame_tick_in_line", ft_cnt, 0);
        check("video_on_639_0", vo_a, 1);
        check("video_on_640_0", vo_b, 0);
        check("py_at_799", o_py, 0);
        tick(1);
        check("line_wrap_px", o_px, 0);
        check("line_wrap_py", o_py, 1);

        // Mid-line reset while hsync is low.
        goto_pix(700, 1, 800);
        check("pre_reset_hsync", o_hs, 0);
        check("pre_reset_video_on", o_vo, 0);
        #1 rst_std = 1'b1;
        #1;
        check("async_rst_px", o_px, 0);
        check("async_rst_py", o_py, 0);
        check("async_rst_hsync", o_hs, 1);
        check("async_rst_ptick", o_pt, 0);
        check("async_rst_video_on", o_vo, 1);
        #2 rst_std = 1'b0;
        tick(3);
        check("restart_tick_early", o_pt, 0);
        tick(1);
        check("restart_tick", o_pt, 1);
        check("restart_px", o_px, 0);
        check("restart_frame_tick", o_ft, 1);

        // ---------------- CLK_DIV = 1, default geometry ----------------
        sel = 1;
        rst_std = 1'b1;
        rst_fast = 1'b0;
        tick(1);
        check("fast_tick_first_clk", o_pt, 1);
        check("fast_frame_tick", o_ft, 1);
        check("fast_px0", o_px, 0);
        n = 0; hs_low = 0; hs_min = 1023; pt_low = 0;
        do begin
            tick(1);
            n++;
            if (o_pt !== 1'b1) pt_low++;
            if (o_hs === 1'b0) begin
                hs_low++;
                if (o_px < hs_min) hs_min = o_px;
            end
        end while (!(o_px == 0 && o_py == 1) && n < 1000);
        check("fast_line_clks", n, 800);
        check("fast_tick_gaps", pt_low, 0);
        check("fast_hsync_low_clks", hs_low, 96);
        check("fast_hsync_first_px", hs_min, 656);

        // ---------------- small geometry, CLK_DIV = 2 ----------------
        sel = 2;
        rst_fast = 1'b1;
        rst_small = 1'b0;
        tick(1);
        check("small_tick_early", o_pt, 0);
        tick(1);
        check("small_first_tick", o_pt, 1);
        check("small_first_frame_tick", o_ft, 1);

        bad = 0; hs_low = 0; vs_low = 0; vs_min = 1023; vs_max = 0; ft_cnt = 0; vo_cnt = 0;
        for (int i = 0; i < 345; i++) begin
            if (o_px == 15 && o_py == 7)  vo_a = o_vo;
            if (o_px == 16 && o_py == 7)  vo_b = o_vo;
            if (o_px == 0  && o_py == 8)  vo_c = o_vo;
            if (o_px == 22 && o_py == 14) vo_d = o_vo;
            next_pix(4, c);
            if (c != 2) bad++;
            if (o_hs === 1'b0) hs_low++;
            if (o_vs === 1'b0) begin
                vs_low++;
                if (o_py < vs_min) vs_min = o_py;
                if (o_py > vs_max) vs_max = o_py;
            end
            if (o_ft === 1'b1) ft_cnt++;
            if (o_vo === 1'b1) vo_cnt++;
        end
        check("small_period_errors", bad, 0);
        check("small_frame_wrap_px", o_px, 0);
        check("small_frame_wrap_py", o_py, 0);
        check("small_frame_ticks", ft_cnt, 1);
        check("small_frame_tick_at_00", o_ft, 1);
        check("small_visible_pixels", vo_cnt, 128);
        check("small_hsync_low_ticks", hs_low, 45);
        check("small_vsync_low_ticks", vs_low, 46);
        check("small_vsync_first_line", vs_min, 10);
        check("small_vsync_last_line", vs_max, 11);
        check("vo_last_visible", vo_a, 1);
        check("vo_right_of_visible", vo_b, 0);
        check("vo_below_visible", vo_c, 0);
        check("vo_last_pixel", vo_d, 0);
        check("vo_origin", o_vo, 1);

        // Mid-frame reset inside both sync pulses.
        goto_pix(19, 10, 400);
        check("mid_hsync_low", o_hs, 0);
        check("mid_vsync_low", o_vs, 0);
        #1 rst_small = 1'b1;
        #1;
        check("mid_rst_px", o_px, 0);
        check("mid_rst_py", o_py, 0);
        check("mid_rst_hsync", o_hs, 1);
        check("mid_rst_vsync", o_vs, 1);
        check("mid_rst_ptick", o_pt, 0);
        check("mid_rst_video_on", o_vo, 1);
        #2 rst_small = 1'b0;
        tick(1);
        check("mid_restart_early", o_pt, 0);
        tick(1);
        check("mid_restart_tick", o_pt, 1);
        check("mid_restart_frame_tick", o_ft, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
